// File: rtl/prod_acc_pkg.sv
// ============================================================================
// Module      : prod_acc_pkg
// Description : Shared types and default widths for the product accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package prod_acc_pkg;

    localparam int PROD_W = 16;
    localparam int CNT_W  = 8;
    localparam int ACC_W  = 24;

    typedef enum logic [0:0] {
        ACC = 1'b0,
        OUT = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/prod_accumulator.sv
// ============================================================================
// Module      : prod_accumulator
// Description : Sums a multiplier product stream per group and presents the
//               group sum, term count and overflow flag on a valid/ready port.
//               Optional MAX_TRACK_EN adds out_max, the largest product seen.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prod_accumulator
    import prod_acc_pkg::*;
#(
    parameter int PROD_W = prod_acc_pkg::PROD_W,
    parameter int CNT_W  = prod_acc_pkg::CNT_W,
    parameter int ACC_W  = prod_acc_pkg::ACC_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
`ifdef MAX_TRACK_EN
    ,
    output logic [PROD_W-1:0] out_max
`endif
);

    state_t             r_state;
    state_t             w_state_next;

    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ovf;
    logic [ACC_W-1:0]   r_sum;
    logic [CNT_W-1:0]   r_count;
    logic               r_ovf_out;

    logic               w_accept;
    logic               w_cnt_max;
    logic [CNT_W-1:0]   w_cnt_sat;
    logic [ACC_W-1:0]   w_acc_sum;
    logic               w_ovf_next;

    assign w_accept   = in_valid && (r_state == ACC);
    assign w_cnt_max  = &r_cnt;
    assign w_cnt_sat  = w_cnt_max ? r_cnt : (r_cnt + CNT_W'(1));
    assign w_acc_sum  = r_acc + ACC_W'(in_prod);
    // A term arriving while the counter is pinned is one the count cannot represent.
    assign w_ovf_next = r_ovf | w_cnt_max;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ACC;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ACC:     if (w_accept && in_last) w_state_next = OUT;
            OUT:     if (out_ready)           w_state_next = ACC;
            default:                          w_state_next = ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc     <= '0;
            r_cnt     <= '0;
            r_ovf     <= 1'b0;
            r_sum     <= '0;
            r_count   <= '0;
            r_ovf_out <= 1'b0;
        end else if (w_accept) begin
            if (in_last) begin
                r_sum     <= w_acc_sum;
                r_count   <= w_cnt_sat;
                r_ovf_out <= w_ovf_next;
                r_acc     <= '0;
                r_cnt     <= '0;
                r_ovf     <= 1'b0;
            end else begin
                r_acc     <= w_acc_sum;
                r_cnt     <= w_cnt_sat;
                r_ovf     <= w_ovf_next;
            end
        end
    end

`ifdef MAX_TRACK_EN
    logic [PROD_W-1:0]  r_max;
    logic [PROD_W-1:0]  r_max_out;
    logic [PROD_W-1:0]  w_max_next;

    assign w_max_next = (in_prod > r_max) ? in_prod : r_max;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_max     <= '0;
            r_max_out <= '0;
        end else if (w_accept) begin
            if (in_last) begin
                r_max_out <= w_max_next;
                r_max     <= '0;
            end else begin
                r_max     <= w_max_next;
            end
        end
    end

    assign out_max = r_max_out;
`endif

    // Handshake flags come straight from the state register, so out_ready never reaches in_ready.
    assign in_ready  = (r_state == ACC);
    assign out_valid = (r_state == OUT);
    assign out_sum   = r_sum;
    assign out_count = r_count;
    assign out_ovf   = r_ovf_out;

endmodule

`default_nettype wire

// File: tb/tb_prod_accumulator.sv
// ============================================================================
// Module      : tb_prod_accumulator
// Description : Self-checking bench for prod_accumulator against a group-level
//               reference model (MAX_TRACK_EN also checks out_max).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_prod_accumulator;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_prod;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_sum;
    logic [7:0]  out_count;
    logic        out_ovf;
`ifdef MAX_TRACK_EN
    logic [15:0] out_max;
`endif

    prod_accumulator dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_prod   (in_prod),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count),
        .out_ovf   (out_ovf)
`ifdef MAX_TRACK_EN
        ,
        .out_max   (out_max)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;

    // Reference model: products of the open group, and the expected output registers.
    int unsigned grp[$];
    logic        m_pending = 1'b0;
    logic [23:0] e_sum     = '0;
    logic [7:0]  e_cnt     = '0;
    logic        e_ovf     = 1'b0;
    logic [15:0] e_max     = '0;
    logic        accepted;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic close_group();
        longint      s  = 0;
        int unsigned mx = 0;
        foreach (grp[i]) begin
            s += longint'(grp[i]);
            if (grp[i] > mx) mx = grp[i];
        end
        e_sum = 24'(s % (longint'(1) << 24));
        e_cnt = (grp.size() > 255) ? 8'd255 : 8'(grp.size());
        e_ovf = (grp.size() > 255);
        e_max = 16'(mx);
        grp.delete();
        m_pending = 1'b1;
    endtask

    task automatic cycle(input logic v, input logic [15:0] p, input logic l,
                         input logic ordy, input logic r);
        rst = r; in_valid = v; in_prod = p; in_last = l; out_ready = ordy;
        accepted = 1'b0;
        if (r) begin
            grp.delete();
            m_pending = 1'b0;
            e_sum = '0; e_cnt = '0; e_ovf = 1'b0; e_max = '0;
        end else if (m_pending) begin
            if (ordy) m_pending = 1'b0;
        end else if (v) begin
            accepted = 1'b1;
            grp.push_back(int'(p));
            if (l) close_group();
        end
        @(posedge clk);
        #1;
        chk("in_ready",  64'(in_ready),  64'(!m_pending));
        chk("out_valid", 64'(out_valid), 64'(m_pending));
        chk("out_sum",   64'(out_sum),   64'(e_sum));
        chk("out_count", 64'(out_count), 64'(e_cnt));
        chk("out_ovf",   64'(out_ovf),   64'(e_ovf));
`ifdef MAX_TRACK_EN
        chk("out_max",   64'(out_max),   64'(e_max));
`endif
    endtask

    task automatic send(input logic [15:0] p, input logic l);
        int guard = 0;
        do begin
            cycle(1'b1, p, l, 1'($urandom_range(0, 1)), 1'b0);
            guard++;
        end while (!accepted && guard < 200);
        if (!accepted) begin
            checks++;
            failures++;
            $error("FAIL accept_timeout observed=%0d expected=%0d", 0, 1);
        end
    endtask

    initial begin
        // Reset state
        cycle(1'b0, 16'd0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 16'd0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 16'd0, 1'b0, 1'b0, 1'b0);

        // Three-term group, result taken immediately
        cycle(1'b1, 16'd100,   1'b0, 1'b1, 1'b0);
        cycle(1'b1, 16'd200,   1'b0, 1'b1, 1'b0);
        cycle(1'b1, 16'd65025, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 16'd0,     1'b0, 1'b1, 1'b0);
        cycle(1'b0, 16'd0,     1'b0, 1'b1, 1'b0);

        // Single-term group
        cycle(1'b1, 16'd7, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 16'd0, 1'b0, 1'b1, 1'b0);

        // Backpressure: pending result held while a beat waits
        cycle(1'b1, 16'd5, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b1, 16'd9, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 16'd9, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 16'd9, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 16'd0, 1'b0, 1'b1, 1'b0);

        // Counter saturation and overflow
        for (int i = 0; i < 255; i++) cycle(1'b1, 16'd65025, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 16'd65025, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 16'd0,     1'b0, 1'b1, 1'b0);

        // Reset mid-group discards the partial sum
        cycle(1'b1, 16'd500, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 16'd600, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 16'd0,   1'b0, 1'b1, 1'b1);
        cycle(1'b0, 16'd0,   1'b0, 1'b1, 1'b0);
        cycle(1'b1, 16'd9,   1'b1, 1'b1, 1'b0);
        cycle(1'b0, 16'd0,   1'b0, 1'b1, 1'b0);

        // Reset while a result is pending
        cycle(1'b1, 16'd77, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 16'd0,  1'b0, 1'b0, 1'b1);
        cycle(1'b0, 16'd0,  1'b0, 1'b0, 1'b0);

        // Group with a distinct maximum
        cycle(1'b1, 16'd10,   1'b0, 1'b1, 1'b0);
        cycle(1'b1, 16'd4000, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 16'd35,   1'b1, 1'b1, 1'b0);
        cycle(1'b0, 16'd0,    1'b0, 1'b1, 1'b0);

        // Random groups of multiplier products with idle gaps and random backpressure
        for (int g = 0; g < 40; g++) begin
            int n = int'($urandom_range(1, 12));
            for (int b = 0; b < n; b++) begin
                while ($urandom_range(0, 3) == 0)
                    cycle(1'b0, 16'($urandom), 1'b1, 1'($urandom_range(0, 1)), 1'b0);
                send(16'($urandom_range(0, 255) * $urandom_range(0, 255)), (b == n - 1));
            end
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, 16'd0, 1'b0, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
